// File: rtl/myproject_mac_sched_pkg.sv
// Shared types and widths for the MAC scheduler: FSM encoding, datapath widths
// and the saturation limits applied to the final result.
package myproject_mac_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned RES_W = 16;
  localparam int unsigned X_W   = 12;
  localparam int unsigned W_W   = 8;
  localparam int unsigned P_W   = 20;

  localparam logic signed [RES_W-1:0] RES_MAX = 16'sh7FFF;
  localparam logic signed [RES_W-1:0] RES_MIN = 16'sh8000;

endpackage

// File: rtl/myproject_mul_12ns_8s_20_1_1.sv
// Combinational 12-bit unsigned x 8-bit signed multiplier, 20-bit signed product.
module myproject_mul_12ns_8s_20_1_1
  import myproject_mac_sched_pkg::*;
(
  input  logic        [X_W-1:0] din0,
  input  logic signed [W_W-1:0] din1,
  output logic signed [P_W-1:0] dout
);

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;

  always_comb begin
    a_ext = $signed({{(P_W-X_W){1'b0}}, din0});
    b_ext = P_W'(din1);
    dout  = a_ext * b_ext;
  end

endmodule

// File: rtl/myproject_mac_sched.sv
// Dot-product MAC scheduler: streams N_IN activations against an external weight
// ROM, accumulates onto a bias and returns a saturated 16-bit result.
module myproject_mac_sched
  import myproject_mac_sched_pkg::*;
#(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned ACC_W = 25,
  localparam int unsigned K_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  output logic                    ap_idle,
  output logic                    ap_ready,
  output logic                    ap_done,
  input  logic signed [P_W-1:0]   bias,
  input  logic        [X_W-1:0]   x_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic        [K_W-1:0]   w_addr,
  input  logic signed [W_W-1:0]   w_data,
  output logic signed [RES_W-1:0] res_data,
  output logic                    res_ovf
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(RES_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(RES_MIN);
  localparam logic        [K_W-1:0]   K_LAST = K_W'(N_IN - 1);

  state_e                    state_q, state_d;
  logic        [K_W-1:0]     k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [X_W-1:0]     x_q, x_d;
  logic                      pv_q, pv_d;
  logic signed [RES_W-1:0]   res_q, res_d;
  logic                      ovf_q, ovf_d;

  logic signed [P_W-1:0]     prod;
  logic                      accept;
  logic                      last;

  myproject_mul_12ns_8s_20_1_1 u_mul (
    .din0 (x_q),
    .din1 (w_data),
    .dout (prod)
  );

  assign accept = (state_q == S_RUN) && x_valid;
  assign last   = (k_q == K_LAST);

  always_comb begin
    ap_idle  = (state_q == S_IDLE);
    x_ready  = (state_q == S_RUN);
    ap_done  = (state_q == S_DONE);
    ap_ready = accept && last;
    w_addr   = (state_q == S_RUN) ? k_q : '0;
    res_data = res_q;
    res_ovf  = ovf_q;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    x_d     = x_q;
    pv_d    = 1'b0;
    res_d   = res_q;
    ovf_d   = ovf_q;

    // The product of the x registered last cycle meets the ROM word for that k now.
    if (pv_q) begin
      acc_d = acc_q + ACC_W'(prod);
    end

    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d = S_RUN;
          acc_d   = ACC_W'(bias);
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          x_d  = x_data;
          pv_d = 1'b1;
          if (last) begin
            state_d = S_DRAIN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // The final product lands this cycle, so clamp the updated sum, not acc_q.
        state_d = S_DONE;
        if (acc_d > SAT_HI) begin
          res_d = RES_MAX;
          ovf_d = 1'b1;
        end else if (acc_d < SAT_LO) begin
          res_d = RES_MIN;
          ovf_d = 1'b1;
        end else begin
          res_d = acc_d[RES_W-1:0];
          ovf_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      pv_q    <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      pv_q    <= pv_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
